sdram_dl_writer: RTL and testbench

//  Initiator for the SDRAM controller's toggle-handshake write ports. Takes the HPS ROM download

---
 rtl/sdram_dl_pkg.sv | 21 ++
 rtl/toggle_req_port.sv | 37 +++
 rtl/sdram_dl_writer.sv | 106 ++++++++++
 tb/tb_sdram_dl_writer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_dl_pkg.sv
// sdram_dl_pkg: shared types and helpers for the SDRAM download writer
package sdram_dl_pkg;
  localparam int ADDR_W = 25;
  localparam logic [1:0] DS_LO = 2'b01;
  localparam logic [1:0] DS_HI = 2'b10;
  localparam logic [1:0] DS_BOTH = 2'b11;
  typedef enum logic [1:0] {SYNC, IDLE, WAIT, FLUSH} state_t;
  typedef struct packed {
    logic v;
    logic full;
    logic r;
    logic [22:0] a;
    logic [15:0] d;
    logic [1:0] ds;
  } pend_t;
  function automatic logic [22:0] word_addr(input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] base, input logic p2);
    logic [ADDR_W-1:0] off;
    off = p2 ? addr - base : addr;
    return off[23:1];
  endfunction
endpackage

// File: rtl/toggle_req_port.sv
// toggle_req_port: holds one SDRAM write request and owns its toggle req line
module toggle_req_port
  import sdram_dl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        sync,
  input  logic        issue,
  input  logic [22:0] a_in,
  input  logic [15:0] d_in,
  input  logic [1:0]  ds_in,
  input  logic        ack,
  output logic        req,
  output logic [22:0] a,
  output logic [15:0] d,
  output logic [1:0]  ds,
  output logic        we,
  output logic        done
);
  assign done = ack == req;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      req <= 1'b0;
      a <= '0;
      d <= '0;
      ds <= '0;
      we <= 1'b0;
    end else if (sync) begin
      req <= ack;
    end else if (issue) begin
      req <= ~req;
      a <= a_in;
      d <= d_in;
      ds <= ds_in;
      we <= 1'b1;
    end
endmodule

// File: rtl/sdram_dl_writer.sv
// sdram_dl_writer: packs ioctl download bytes into 16-bit words and writes them
// through two toggle-handshake SDRAM ports, one request outstanding at a time.
module sdram_dl_writer
  import sdram_dl_pkg::*;
#(
  parameter logic [7:0]        ROM_INDEX = 8'd0,
  parameter logic [ADDR_W-1:0] P2_BASE   = 25'h0100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              port1_req,
  input  logic              port1_ack,
  output logic [22:0]       port1_a,
  output logic [1:0]        port1_ds,
  output logic [15:0]       port1_d,
  output logic              port1_we,
  output logic              port2_req,
  input  logic              port2_ack,
  output logic [22:0]       port2_a,
  output logic [1:0]        port2_ds,
  output logic [15:0]       port2_d,
  output logic              port2_we,
  output logic              busy,
  output logic [23:0]       words_written
);
  state_t state, state_n;
  pend_t p, pn;
  logic dl_q, h_v, h_vn;
  logic [ADDR_W-1:0] h_addr, ba;
  logic [7:0] h_d, bd;
  logic [22:0] wa;
  logic acc, issue, fall, rise, in_wait, done, done1, done2, pv, src, reg_b, odd_b, mis;
  assign in_wait = state == WAIT || state == FLUSH;
  assign done = done1 && done2;
  // p.full outside IDLE is the holding slot that stalls the HPS; h_v is a byte parked by a mismatch
  assign ioctl_wait = (p.full && state != IDLE) || h_v || state == FLUSH;
  assign busy = p.v || h_v || in_wait;
  assign acc = ioctl_download && ioctl_index == ROM_INDEX && ioctl_wr && !ioctl_wait;
  assign issue = state == IDLE && p.full;
  assign fall = dl_q && !ioctl_download;
  assign rise = !dl_q && ioctl_download;
  assign pv = p.v && !issue;
  assign src = acc || (h_v && !pv);
  assign ba = acc ? ioctl_addr : h_addr;
  assign bd = acc ? ioctl_dout : h_d;
  assign reg_b = ba >= P2_BASE;
  assign odd_b = ba[0];
  assign wa = word_addr(ba, P2_BASE, reg_b);
  assign mis = pv && (!odd_b || wa != p.a || reg_b != p.r);
  assign h_vn = (src && mis) || (h_v && pv);
  always_comb begin
    pn = pv ? p : '0;
    if (src && mis) begin
      pn.full = 1'b1;
    end else if (src && pv) begin
      pn.d[15:8] = bd;
      pn.ds = DS_BOTH;
      pn.full = 1'b1;
    end else if (src) begin
      pn.v = 1'b1;
      pn.full = odd_b;
      pn.r = reg_b;
      pn.a = wa;
      pn.d = odd_b ? {bd, 8'h00} : {8'h00, bd};
      pn.ds = odd_b ? DS_HI : DS_LO;
    end
    if (fall && pn.v) pn.full = 1'b1;
    state_n = state == SYNC ? IDLE : issue ? (h_v ? FLUSH : WAIT) : (in_wait && done) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= SYNC;
      p <= '0;
      h_v <= 1'b0;
      h_addr <= '0;
      h_d <= '0;
      dl_q <= 1'b0;
      words_written <= '0;
    end else begin
      state <= state_n;
      p <= pn;
      h_v <= h_vn;
      dl_q <= ioctl_download;
      if (acc && mis) begin
        h_addr <= ioctl_addr;
        h_d <= ioctl_dout;
      end
      words_written <= rise ? '0 : (in_wait && done) ? words_written + 24'd1 : words_written;
    end
  toggle_req_port u_p1 (
    .clk(clk), .reset(reset), .sync(state == SYNC), .issue(issue && !p.r),
    .a_in(p.a), .d_in(p.d), .ds_in(p.ds), .ack(port1_ack),
    .req(port1_req), .a(port1_a), .d(port1_d), .ds(port1_ds), .we(port1_we), .done(done1)
  );
  toggle_req_port u_p2 (
    .clk(clk), .reset(reset), .sync(state == SYNC), .issue(issue && p.r),
    .a_in(p.a), .d_in(p.d), .ds_in(p.ds), .ack(port2_ack),
    .req(port2_req), .a(port2_a), .d(port2_d), .ds(port2_ds), .we(port2_we), .done(done2)
  );
endmodule

// File: tb/tb_sdram_dl_writer.sv
// tb_sdram_dl_writer: directed bench with a delayed-ack SDRAM responder logging every write
module tb_sdram_dl_writer;
  logic clk, reset, ioctl_download, ioctl_wr, ioctl_wait;
  logic [7:0] ioctl_index, ioctl_dout;
  logic [24:0] ioctl_addr;
  logic port1_req, port1_ack, port1_we, port2_req, port2_ack, port2_we, busy;
  logic [22:0] port1_a, port2_a;
  logic [1:0] port1_ds, port2_ds;
  logic [15:0] port1_d, port2_d;
  logic [23:0] words_written;
  int errors = 0, checks = 0, dly = 2, cnt1 = 0, cnt2 = 0, wait_cyc = 0;
  logic freeze = 1'b0;
  logic [42:0] wlog[$];
  logic [42:0] w;

  sdram_dl_writer dut (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a), .port1_ds(port1_ds),
    .port1_d(port1_d), .port1_we(port1_we),
    .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a), .port2_ds(port2_ds),
    .port2_d(port2_d), .port2_we(port2_we),
    .busy(busy), .words_written(words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (ioctl_wait) wait_cyc++;

  // log entry: {we, port, a, d, ds}
  always @(posedge clk) begin
    #1;
    if (!freeze && port1_req !== port1_ack) begin
      if (cnt1 >= dly) begin
        wlog.push_back({port1_we, 1'b0, port1_a, port1_d, port1_ds});
        port1_ack = port1_req;
        cnt1 = 0;
      end else cnt1++;
    end
    if (!freeze && port2_req !== port2_ack) begin
      if (cnt2 >= dly) begin
        wlog.push_back({port2_we, 1'b1, port2_a, port2_d, port2_ds});
        port2_ack = port2_req;
        cnt2 = 0;
      end else cnt2++;
    end
  end

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    ioctl_wr = 1'b0;
    while (ioctl_wait && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL wait_timeout: ioctl_wait stuck high at byte addr %h", a);
    end
    ioctl_wr = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
  endtask

  task automatic idle_wr();
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    int t = 0;
    while (wlog.size() < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (wlog.size() < n) begin
      checks++; errors++;
      $display("FAIL write_timeout: got %0d writes, required %0d", wlog.size(), n);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy still high");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    port1_ack = 1'b0; port2_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (port1_req !== 1'b0) begin errors++; $display("FAIL rst_req1: got %b want 0", port1_req); end
    checks++; if (port2_req !== 1'b0) begin errors++; $display("FAIL rst_req2: got %b want 0", port2_req); end
    checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL rst_wait: got %b want 0", ioctl_wait); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (words_written !== 24'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", words_written); end
    checks++; if ({port1_we, port1_ds, port1_d, port1_a} !== '0) begin errors++; $display("FAIL rst_port1: got we=%b ds=%b d=%h a=%h want all 0", port1_we, port1_ds, port1_d, port1_a); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (port1_req !== 1'b0) begin errors++; $display("FAIL sync_req1: got %b want 0", port1_req); end
  endtask

  task automatic test_port1_word();
    ioctl_download = 1'b1;
    send_byte(25'd0, 8'h12);
    send_byte(25'd1, 8'h34);
    idle_wr();
    checks++; if (port1_req !== 1'b0) begin errors++; $display("FAIL t1_latency_early: req got %b want 0", port1_req); end
    @(negedge clk);
    checks++; if (port1_req !== 1'b1) begin errors++; $display("FAIL t1_issue: req got %b want 1", port1_req); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy: got %b want 1", busy); end
    wait_writes(1);
    w = wlog.pop_front();
    checks++; if (w !== {1'b1, 1'b0, 23'd0, 16'h3412, 2'b11}) begin errors++; $display("FAIL t1_write: got %h want %h", w, {1'b1, 1'b0, 23'd0, 16'h3412, 2'b11}); end
    wait_idle();
    checks++; if (words_written !== 24'd1) begin errors++; $display("FAIL t1_count: got %0d want 1", words_written); end
    checks++; if (port2_req !== 1'b0) begin errors++; $display("FAIL t1_req2: got %b want 0", port2_req); end
  endtask

  task automatic test_port2_word();
    send_byte(25'h0100000, 8'h56);
    send_byte(25'h0100001, 8'h78);
    idle_wr();
    wait_writes(1);
    w = wlog.pop_front();
    checks++; if (w !== {1'b1, 1'b1, 23'd0, 16'h7856, 2'b11}) begin errors++; $display("FAIL t2_write: got %h want %h", w, {1'b1, 1'b1, 23'd0, 16'h7856, 2'b11}); end
    wait_idle();
    checks++; if (port1_req !== 1'b1) begin errors++; $display("FAIL t2_req1: got %b want 1", port1_req); end
    checks++; if (words_written !== 24'd2) begin errors++; $display("FAIL t2_count: got %0d want 2", words_written); end
  endtask

  task automatic test_back_to_back();
    int w0;
    logic [42:0] exp [3];
    exp[0] = {1'b1, 1'b0, 23'd8, 16'hA1A0, 2'b11};
    exp[1] = {1'b1, 1'b0, 23'd9, 16'hA3A2, 2'b11};
    exp[2] = {1'b1, 1'b0, 23'd10, 16'hA5A4, 2'b11};
    dly = 20;
    w0 = wait_cyc;
    for (int i = 0; i < 6; i++) send_byte(25'h10 + 25'(i), 8'hA0 + 8'(i));
    idle_wr();
    wait_writes(3);
    wait_idle();
    checks++; if (wait_cyc - w0 < 20) begin errors++; $display("FAIL t3_wait: high for %0d cycles, want at least 20", wait_cyc - w0); end
    for (int i = 0; i < 3; i++) begin
      w = (wlog.size() > 0) ? wlog.pop_front() : '0;
      checks++; if (w !== exp[i]) begin errors++; $display("FAIL t3_write%0d: got %h want %h", i, w, exp[i]); end
    end
    checks++; if (words_written !== 24'd5) begin errors++; $display("FAIL t3_count: got %0d want 5", words_written); end
    dly = 2;
  endtask

  task automatic test_mismatch();
    send_byte(25'd4, 8'hAA);
    send_byte(25'd10, 8'hBB);
    idle_wr();
    wait_writes(1);
    w = wlog.pop_front();
    checks++; if (w[41] !== 1'b0 || w[40:18] !== 23'd2 || w[1:0] !== 2'b01 || w[9:2] !== 8'hAA) begin errors++; $display("FAIL t4_flush: got port=%b a=%0d ds=%b dlo=%h want 0 2 01 aa", w[41], w[40:18], w[1:0], w[9:2]); end
    repeat (10) @(negedge clk);
    checks++; if (wlog.size() != 0) begin errors++; $display("FAIL t4_extra: got %0d writes want 0", wlog.size()); end
    checks++; if (busy !== 1'b1 || ioctl_wait !== 1'b0) begin errors++; $display("FAIL t4_pending: busy=%b wait=%b want 1 0", busy, ioctl_wait); end
    ioctl_download = 1'b0;
    wait_writes(1);
    w = wlog.pop_front();
    checks++; if (w[41] !== 1'b0 || w[40:18] !== 23'd5 || w[1:0] !== 2'b01 || w[9:2] !== 8'hBB) begin errors++; $display("FAIL t4_pend_write: got port=%b a=%0d ds=%b dlo=%h want 0 5 01 bb", w[41], w[40:18], w[1:0], w[9:2]); end
    wait_idle();
    checks++; if (words_written !== 24'd7) begin errors++; $display("FAIL t4_count: got %0d want 7", words_written); end
  endtask

  task automatic test_end_flush();
    @(negedge clk);
    ioctl_download = 1'b1;
    @(negedge clk);
    checks++; if (words_written !== 24'd0) begin errors++; $display("FAIL t5_clear: got %0d want 0", words_written); end
    send_byte(25'd8, 8'h55);
    idle_wr();
    ioctl_download = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t5_busy_pend: got %b want 1", busy); end
    wait_writes(1);
    w = wlog.pop_front();
    checks++; if (w[41] !== 1'b0 || w[40:18] !== 23'd4 || w[1:0] !== 2'b01 || w[9:2] !== 8'h55) begin errors++; $display("FAIL t5_flush: got port=%b a=%0d ds=%b dlo=%h want 0 4 01 55", w[41], w[40:18], w[1:0], w[9:2]); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t5_busy_ack: got %b want 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_busy_fall: got %b want 0", busy); end
    checks++; if (words_written !== 24'd1) begin errors++; $display("FAIL t5_count: got %0d want 1", words_written); end
  endtask

  task automatic test_reset_mid_wait();
    freeze = 1'b1;
    @(negedge clk);
    ioctl_download = 1'b1;
    send_byte(25'h20, 8'h01);
    send_byte(25'h21, 8'h02);
    idle_wr();
    @(negedge clk);
    checks++; if (port1_req !== 1'b0 || port1_ack !== 1'b1) begin errors++; $display("FAIL t6_inflight: req=%b ack=%b want 0 1", port1_req, port1_ack); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (port1_req !== 1'b0 || busy !== 1'b0 || words_written !== 24'd0) begin errors++; $display("FAIL t6_reset: req=%b busy=%b count=%0d want 0 0 0", port1_req, busy, words_written); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (port1_req !== 1'b1 || port2_req !== 1'b1) begin errors++; $display("FAIL t6_sync: req1=%b req2=%b want 1 1", port1_req, port2_req); end
    freeze = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (wlog.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL t6_spurious: writes=%0d busy=%b want 0 0", wlog.size(), busy); end
    ioctl_index = 8'd5;
    send_byte(25'h30, 8'h11);
    send_byte(25'h31, 8'h22);
    idle_wr();
    repeat (10) @(negedge clk);
    checks++; if (wlog.size() != 0 || busy !== 1'b0 || words_written !== 24'd0) begin errors++; $display("FAIL t6_index: writes=%0d busy=%b count=%0d want 0 0 0", wlog.size(), busy, words_written); end
  endtask

  initial begin
    test_reset();
    test_port1_word();
    test_port2_word();
    test_back_to_back();
    test_mismatch();
    test_end_flush();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
